// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: DEPTH = 2**ADDR_WIDTH entries of DATA_WIDTH bits,
// registered read data, one-cycle ack/err pulses per request, and occupancy flags
// decoded combinationally from data_count.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;

    // Flag decode and acceptance decisions from the pre-edge occupancy.
    always_comb begin
        full_w  = (count_q == DEPTH_C);
        empty_w = (count_q == '0);
        // When full, a simultaneous read frees the slot the write lands in.
        wr_accept = wr_en && (!full_w || rd_en);
        // No write-through: a read on an empty FIFO is always rejected.
        rd_accept = rd_en && !empty_w;
    end

    // Next-state computation for pointers, occupancy, read data and pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        d_out_d  = d_out_q;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            wr_ack_d = 1'b1;
        end else if (wr_en) begin
            wr_err_d = 1'b1;
        end

        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            d_out_d  = mem_q[rd_ptr_q];
            rd_ack_d = 1'b1;
        end else if (rd_en) begin
            rd_err_d = 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            d_out_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            d_out_q  <= d_out_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array: not reset; a write is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset_n && wr_accept) begin
            mem_q[wr_ptr_q] <= d_in;
        end
    end

    // Output drive.
    always_comb begin
        d_out        = d_out_q;
        data_count   = count_q;
        full         = full_w;
        empty        = empty_w;
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        wr_ack       = wr_ack_q;
        wr_err       = wr_err_q;
        rd_ack       = rd_ack_q;
        rd_err       = rd_err_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with default parameters (8 x 32).
module tb_sync_fifo_param;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] d_in;
    logic        rd_en;
    logic [31:0] d_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  data_count;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;

    int checks;
    int errors;

    sync_fifo_param #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .d_in        (d_in),
        .rd_en       (rd_en),
        .d_out       (d_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .data_count  (data_count),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            d_in  = $urandom;
            tick();
        end
        checks++;
        if (d_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h want %h", d_out, 32'h0);
        end
        checks++;
        if (data_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", data_count);
        end
        checks++;
        if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1100", {empty, almost_empty, full, almost_full});
        end
        checks++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
        end
        reset_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            d_in  = 32'(8'h11 * (i + 1));
            tick();
            checks++;
            if ({wr_ack, wr_err} !== 2'b10) begin
                errors++;
                $display("FAIL fill_ack[%0d]: got %b want 10", i, {wr_ack, wr_err});
            end
            checks++;
            if (data_count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, data_count, i + 1);
            end
            checks++;
            if ({almost_full, full} !== {((i + 1) >= 6), ((i + 1) == 8)}) begin
                errors++;
                $display("FAIL fill_flags[%0d]: got af=%b f=%b want af=%b f=%b", i,
                         almost_full, full, ((i + 1) >= 6), ((i + 1) == 8));
            end
        end
        d_in = 32'h99;
        tick();
        checks++;
        if ({wr_ack, wr_err} !== 2'b01) begin
            errors++;
            $display("FAIL overflow_err: got %b want 01", {wr_ack, wr_err});
        end
        checks++;
        if (data_count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_count: got %0d full=%b want 8 full=1", data_count, full);
        end
        idle();
        tick();
        checks++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_pulses: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (d_out !== 32'(8'h11 * (i + 1)) || {rd_ack, rd_err} !== 2'b10) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h ack/err=%b want %h ack/err=10", i,
                         d_out, {rd_ack, rd_err}, 32'(8'h11 * (i + 1)));
            end
            checks++;
            if (data_count !== 4'(7 - i) || almost_empty !== ((7 - i) <= 2)) begin
                errors++;
                $display("FAIL drain_count[%0d]: got %0d ae=%b want %0d ae=%b", i,
                         data_count, almost_empty, 7 - i, ((7 - i) <= 2));
            end
        end
        tick();
        checks++;
        if ({rd_ack, rd_err} !== 2'b01 || d_out !== 32'h88 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got ack/err=%b dout=%h empty=%b want 01 88 1",
                     {rd_ack, rd_err}, d_out, empty);
        end
        idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            d_in  = 32'h51 + 32'(i);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            d_in  = 32'hA0 + 32'(i);
            tick();
            checks++;
            if (d_out !== ((i < 5) ? (32'h51 + 32'(i)) : 32'hA0) || data_count !== 4'd5) begin
                errors++;
                $display("FAIL wrap_simul[%0d]: got %h cnt=%0d want %h cnt=5", i, d_out,
                         data_count, ((i < 5) ? (32'h51 + 32'(i)) : 32'hA0));
            end
            checks++;
            if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1010) begin
                errors++;
                $display("FAIL wrap_pulses[%0d]: got %b want 1010", i, {wr_ack, wr_err, rd_ack, rd_err});
            end
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (d_out !== 32'hA1 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_drain[%0d]: got %h want %h", i, d_out, 32'hA1 + 32'(i));
            end
        end
        idle();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            d_in  = 32'h10 + 32'(i);
            tick();
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in  = 32'hF0;
        tick();
        checks++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1010 || d_out !== 32'h10 || data_count !== 4'd8) begin
            errors++;
            $display("FAIL full_simul: got pulses=%b dout=%h cnt=%0d want 1010 10 8",
                     {wr_ack, wr_err, rd_ack, rd_err}, d_out, data_count);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (d_out !== ((i < 7) ? (32'h11 + 32'(i)) : 32'hF0)) begin
                errors++;
                $display("FAIL full_simul_drain[%0d]: got %h want %h", i, d_out,
                         ((i < 7) ? (32'h11 + 32'(i)) : 32'hF0));
            end
        end
        idle();
    endtask

    task automatic test_empty_simul();
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in  = 32'hDEAD;
        tick();
        checks++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1001 || data_count !== 4'd1) begin
            errors++;
            $display("FAIL empty_simul: got pulses=%b cnt=%0d want 1001 1",
                     {wr_ack, wr_err, rd_ack, rd_err}, data_count);
        end
        checks++;
        if (d_out !== 32'hF0) begin
            errors++;
            $display("FAIL empty_simul_hold: got %h want %h", d_out, 32'hF0);
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (d_out !== 32'hDEAD || {rd_ack, rd_err} !== 2'b10 || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_simul_read: got %h ack/err=%b empty=%b want dead 10 1",
                     d_out, {rd_ack, rd_err}, empty);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            d_in  = 32'h60 + 32'(i);
            tick();
        end
        reset_n = 1'b0;
        d_in    = 32'h77;
        tick();
        checks++;
        if (data_count !== 4'd0 || empty !== 1'b1 || wr_ack !== 1'b0 || d_out !== 32'h0) begin
            errors++;
            $display("FAIL midreset: got cnt=%0d empty=%b wr_ack=%b dout=%h want 0 1 0 0",
                     data_count, empty, wr_ack, d_out);
        end
        reset_n = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        tick();
        checks++;
        if ({rd_ack, rd_err} !== 2'b01 || d_out !== 32'h0 || data_count !== 4'd0) begin
            errors++;
            $display("FAIL midreset_read: got ack/err=%b dout=%h cnt=%0d want 01 0 0",
                     {rd_ack, rd_err}, d_out, data_count);
        end
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_simul();
        test_empty_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
